// File: rtl/block_warp_issuer_if.sv
// Block assignment and warp issue bundle between dispatcher, issuer and scheduler.
// master: issuer side (drives block_done and warp descriptor); slave: environment side.
interface block_warp_issuer_if #(
  parameter int WARP_SIZE = 32
);
  logic                 block_start;
  logic [31:0]          block_id;
  logic [31:0]          block_dim;
  logic [31:0]          num_threads;
  logic                 block_done;
  logic                 warp_valid;
  logic                 warp_ready;
  logic [31:0]          warp_block_id;
  logic [31:0]          warp_id;
  logic [31:0]          warp_base_tid;
  logic [WARP_SIZE-1:0] warp_mask;
  logic                 warp_retire;

  modport master (
    input  block_start, block_id, block_dim, num_threads,
    input  warp_ready, warp_retire,
    output block_done, warp_valid, warp_block_id,
    output warp_id, warp_base_tid, warp_mask
  );

  modport slave (
    output block_start, block_id, block_dim, num_threads,
    output warp_ready, warp_retire,
    input  block_done, warp_valid, warp_block_id,
    input  warp_id, warp_base_tid, warp_mask
  );
endinterface

// File: rtl/block_warp_issuer.sv
// Splits one dispatched thread block into warps, bounded by resident slots.
// Ports: clk, rst (async active-low), bus (master), busy, protocol_err.
module block_warp_issuer #(
  parameter int WARP_SIZE      = 32,
  parameter int NUM_WARP_SLOTS = 4
) (
  input  logic                clk,
  input  logic                rst,
  block_warp_issuer_if.master bus,
  output logic                busy,
  output logic                protocol_err
);

  localparam logic [31:0] WS32   = 32'(WARP_SIZE);
  localparam logic [31:0] SLOT32 = 32'(NUM_WARP_SLOTS);

  typedef enum logic [2:0] {
    IDLE, SETUP, ISSUE, DONE, RELEASE
  } state_t;

  state_t state_q, state_d;
  logic [31:0] bid_q, bid_d;
  logic [31:0] dim_q, dim_d;
  logic [31:0] nt_q, nt_d;
  logic [31:0] base_q, base_d;
  logic [31:0] nthr_q, nthr_d;
  logic [31:0] nwarps_q, nwarps_d;
  logic [31:0] issued_q, issued_d;
  logic [31:0] retired_q, retired_d;
  logic        valid_q, valid_d;
  logic [31:0] wid_q, wid_d;
  logic [31:0] wtid_q, wtid_d;
  logic [31:0] wbid_q, wbid_d;
  logic [WARP_SIZE-1:0] wmask_q, wmask_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [31:0] base_c, rem_c, nthr_c, nwarps_c;
  logic [31:0] outst, issued_n, retired_n;
  logic        xfer, ret_ok;

  function automatic logic [WARP_SIZE-1:0] lane_mask(
    input logic [31:0] rem
  );
    logic [WARP_SIZE-1:0] m;
    for (int i = 0; i < WARP_SIZE; i++)
      m[i] = (32'(i) < rem);
    return m;
  endfunction

  always_comb begin
    state_d   = state_q;
    bid_d     = bid_q;
    dim_d     = dim_q;
    nt_d      = nt_q;
    base_d    = base_q;
    nthr_d    = nthr_q;
    nwarps_d  = nwarps_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    valid_d   = valid_q;
    wid_d     = wid_q;
    wtid_d    = wtid_q;
    wbid_d    = wbid_q;
    wmask_d   = wmask_q;
    done_d    = 1'b0;
    err_d     = err_q;

    base_c = bid_q * dim_q;
    rem_c  = nt_q - base_c;
    nthr_c = '0;
    if (nt_q > base_c)
      nthr_c = (dim_q < rem_c) ? dim_q : rem_c;
    nwarps_c = nthr_c / WS32
             + (((nthr_c % WS32) != 32'd0) ? 32'd1 : 32'd0);

    outst     = issued_q - retired_q;
    xfer      = valid_q && bus.warp_ready;
    ret_ok    = bus.warp_retire && (state_q == ISSUE)
             && (outst != 32'd0);
    issued_n  = issued_q + (xfer ? 32'd1 : 32'd0);
    retired_n = retired_q + (ret_ok ? 32'd1 : 32'd0);

    if (bus.warp_retire && !ret_ok)
      err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.block_start) begin
          bid_d     = bus.block_id;
          dim_d     = bus.block_dim;
          nt_d      = bus.num_threads;
          issued_d  = '0;
          retired_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        base_d   = base_c;
        nthr_d   = nthr_c;
        nwarps_d = nwarps_c;
        if (nwarps_c == 32'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ISSUE;
          valid_d = 1'b1;
          wid_d   = '0;
          wtid_d  = base_c;
          wbid_d  = bid_q;
          wmask_d = lane_mask(nthr_c);
        end
      end
      ISSUE: begin
        issued_d  = issued_n;
        retired_d = retired_n;
        // Payload tracks issued_n, so it only moves on a transfer.
        wid_d   = issued_n;
        wtid_d  = base_q + issued_n * WS32;
        wmask_d = lane_mask(nthr_q - issued_n * WS32);
        if (retired_n == nwarps_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          valid_d = 1'b0;
        end else begin
          valid_d = (issued_n < nwarps_q)
                 && ((issued_n - retired_n) < SLOT32);
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.block_start)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bid_q     <= '0;
      dim_q     <= '0;
      nt_q      <= '0;
      base_q    <= '0;
      nthr_q    <= '0;
      nwarps_q  <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      valid_q   <= 1'b0;
      wid_q     <= '0;
      wtid_q    <= '0;
      wbid_q    <= '0;
      wmask_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bid_q     <= bid_d;
      dim_q     <= dim_d;
      nt_q      <= nt_d;
      base_q    <= base_d;
      nthr_q    <= nthr_d;
      nwarps_q  <= nwarps_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      valid_q   <= valid_d;
      wid_q     <= wid_d;
      wtid_q    <= wtid_d;
      wbid_q    <= wbid_d;
      wmask_q   <= wmask_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.block_done    = done_q;
  assign bus.warp_valid    = valid_q;
  assign bus.warp_id       = wid_q;
  assign bus.warp_base_tid = wtid_q;
  assign bus.warp_block_id = wbid_q;
  assign bus.warp_mask     = wmask_q;
  assign busy              = busy_q;
  assign protocol_err      = err_q;

endmodule

// File: tb/tb_block_warp_issuer.sv
// Directed bench for block_warp_issuer.
// Drives 1ns after each rising edge and samples there.
module tb_block_warp_issuer;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic protocol_err;
  int   vecs = 0;
  int   errs = 0;
  int   n;

  block_warp_issuer_if #(.WARP_SIZE(32)) bus ();

  block_warp_issuer #(
    .WARP_SIZE(32),
    .NUM_WARP_SLOTS(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_blk(input logic [31:0] id,
                           input logic [31:0] dim,
                           input logic [31:0] nt);
    bus.block_start = 1'b1;
    bus.block_id    = id;
    bus.block_dim   = dim;
    bus.num_threads = nt;
  endtask

  initial begin
    rst             = 1'b0;
    bus.block_start = 1'b0;
    bus.block_id    = '0;
    bus.block_dim   = '0;
    bus.num_threads = '0;
    bus.warp_ready  = 1'b0;
    bus.warp_retire = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.warp_valid), 32'd0);
    chk("rst_done", 32'(bus.block_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(protocol_err), 32'd0);
    chk("rst_wid", bus.warp_id, 32'd0);
    chk("rst_tid", bus.warp_base_tid, 32'd0);
    chk("rst_mask", bus.warp_mask, 32'd0);
    chk("rst_bid", bus.warp_block_id, 32'd0);
    step();
    rst = 1'b1;
    step();

    // full block, two warps: base 128
    start_blk(32'd2, 32'd64, 32'd256);
    bus.warp_ready = 1'b1;
    step();
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_valid", 32'(bus.warp_valid), 32'd0);
    step();
    chk("t1_w0_valid", 32'(bus.warp_valid), 32'd1);
    chk("t1_w0_id", bus.warp_id, 32'd0);
    chk("t1_w0_tid", bus.warp_base_tid, 32'd128);
    chk("t1_w0_mask", bus.warp_mask, 32'hFFFF_FFFF);
    chk("t1_w0_bid", bus.warp_block_id, 32'd2);
    step();
    chk("t1_w1_valid", 32'(bus.warp_valid), 32'd1);
    chk("t1_w1_id", bus.warp_id, 32'd1);
    chk("t1_w1_tid", bus.warp_base_tid, 32'd160);
    chk("t1_w1_mask", bus.warp_mask, 32'hFFFF_FFFF);
    step();
    chk("t1_drained", 32'(bus.warp_valid), 32'd0);
    bus.warp_retire = 1'b1;
    step();
    chk("t1_ret1_done", 32'(bus.block_done), 32'd0);
    step();
    bus.warp_retire = 1'b0;
    chk("t1_done", 32'(bus.block_done), 32'd1);
    step();
    chk("t1_done_pulse", 32'(bus.block_done), 32'd0);
    chk("t1_release_busy", 32'(busy), 32'd1);
    bus.block_start = 1'b0;
    step();
    chk("t1_idle", 32'(busy), 32'd0);

    // partial last block: base 192, 8 threads
    bus.warp_ready = 1'b0;
    start_blk(32'd3, 32'd64, 32'd200);
    step();
    step();
    chk("t2_valid", 32'(bus.warp_valid), 32'd1);
    chk("t2_tid", bus.warp_base_tid, 32'd192);
    chk("t2_mask", bus.warp_mask, 32'h0000_00FF);
    step();
    chk("t2_hold_valid", 32'(bus.warp_valid), 32'd1);
    chk("t2_hold_mask", bus.warp_mask, 32'h0000_00FF);
    bus.warp_ready = 1'b1;
    step();
    chk("t2_after_xfer", 32'(bus.warp_valid), 32'd0);
    bus.warp_ready  = 1'b0;
    bus.warp_retire = 1'b1;
    step();
    bus.warp_retire = 1'b0;
    chk("t2_done", 32'(bus.block_done), 32'd1);
    step();
    bus.block_start = 1'b0;
    step();
    chk("t2_idle", 32'(busy), 32'd0);

    // slot limit: 8 warps, 4 slots
    bus.warp_ready = 1'b1;
    start_blk(32'd0, 32'd256, 32'd1024);
    step();
    step();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.warp_valid && bus.warp_ready) n++;
      step();
    end
    chk("t3_xfers", 32'(n), 32'd4);
    chk("t3_stall", 32'(bus.warp_valid), 32'd0);
    bus.warp_retire = 1'b1;
    step();
    bus.warp_retire = 1'b0;
    chk("t3_w4_valid", 32'(bus.warp_valid), 32'd1);
    chk("t3_w4_id", bus.warp_id, 32'd4);
    chk("t3_w4_tid", bus.warp_base_tid, 32'd128);
    step();
    chk("t3_one_more", 32'(bus.warp_valid), 32'd0);
    bus.warp_ready  = 1'b0;
    bus.warp_retire = 1'b1;
    step();
    bus.warp_retire = 1'b0;
    chk("t3_w5_valid", 32'(bus.warp_valid), 32'd1);
    chk("t3_w5_id", bus.warp_id, 32'd5);

    // async reset mid-issue
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.warp_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_wid", bus.warp_id, 32'd0);
    bus.block_start = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t6_no_done", 32'(bus.block_done), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    // empty block: base 320 >= 256
    start_blk(32'd5, 32'd64, 32'd256);
    step();
    chk("t4_c1_valid", 32'(bus.warp_valid), 32'd0);
    step();
    chk("t4_done", 32'(bus.block_done), 32'd1);
    chk("t4_valid", 32'(bus.warp_valid), 32'd0);

    // start held after done: no relaunch
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_hold_done", 32'(bus.block_done), 32'd0);
      chk("t5_hold_valid", 32'(bus.warp_valid), 32'd0);
      chk("t5_hold_busy", 32'(busy), 32'd1);
    end
    bus.block_start = 1'b0;
    step();
    chk("t5_idle", 32'(busy), 32'd0);

    // new block 7: base 448, 2 warps
    start_blk(32'd7, 32'd64, 32'd1024);
    bus.warp_ready = 1'b1;
    step();
    step();
    chk("t5_w0_valid", 32'(bus.warp_valid), 32'd1);
    chk("t5_w0_bid", bus.warp_block_id, 32'd7);
    chk("t5_w0_tid", bus.warp_base_tid, 32'd448);
    step();
    chk("t5_w1_bid", bus.warp_block_id, 32'd7);
    chk("t5_w1_tid", bus.warp_base_tid, 32'd480);
    step();
    chk("t5_drained", 32'(bus.warp_valid), 32'd0);
    bus.warp_retire = 1'b1;
    step();
    chk("t5_ret1_done", 32'(bus.block_done), 32'd0);
    step();
    bus.warp_retire = 1'b0;
    chk("t5_done", 32'(bus.block_done), 32'd1);
    step();
    bus.block_start = 1'b0;
    step();
    chk("t5_end_idle", 32'(busy), 32'd0);
    chk("t5_no_err", 32'(protocol_err), 32'd0);

    // stray retire in IDLE
    bus.warp_retire = 1'b1;
    step();
    bus.warp_retire = 1'b0;
    chk("t7_err", 32'(protocol_err), 32'd1);
    step();
    step();
    chk("t7_err_sticky", 32'(protocol_err), 32'd1);
    rst = 1'b0;
    #1;
    chk("t7_err_clr", 32'(protocol_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/block_warp_issuer.md
# block_warp_issuer

Core-side receiver of thread-block assignments from the block dispatcher. It latches one block per `block_start` assertion and splits it into warps of `WARP_SIZE` threads. Warps go to the core's warp scheduler over a valid/ready handshake, with at most `NUM_WARP_SLOTS` resident at once. When every warp has retired, it returns a one-cycle `block_done` pulse to the dispatcher. One instance sits in each compute unit.

## Interface
- `WARP_SIZE`, 32: threads per warp.
- `NUM_WARP_SLOTS`, 4: maximum warps issued but not yet retired.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `block_start` in 1: block assignment from the dispatcher. Held high until `block_done` is observed.
- `block_id` in 32: assigned block index. Valid while `block_start` is high.
- `block_dim` in 32: threads per block (kernel constant).
- `num_threads` in 32: total threads launched (kernel constant).
- `block_done` out 1: one-cycle pulse when the block has fully retired.
- `warp_valid` out 1: warp descriptor valid.
- `warp_ready` in 1: scheduler accepts the descriptor.
- `warp_block_id` out 32: block of the issued warp.
- `warp_id` out 32: warp index within the block (0-based).
- `warp_base_tid` out 32: global thread id of lane 0.
- `warp_mask` out WARP_SIZE: active-lane mask.
- `warp_retire` in 1: one-cycle pulse; one resident warp has finished.
- `busy` out 1: high in every state except IDLE.
- `protocol_err` out 1: sticky error flag; cleared only by reset.

## Operation
- States: IDLE, SETUP, ISSUE, DONE, RELEASE.
- IDLE, `block_start`=1 at an edge:
  - Latch `block_id`, `block_dim` and `num_threads`.
  - Go to SETUP.
- SETUP (one cycle):
  - `base` = `block_id`*`block_dim`, truncated to 32 bits.
  - `nthr` = (`num_threads` > `base`) ? min(`block_dim`, `num_threads`-`base`) : 0.
  - `nwarps` = ceil(`nthr`/`WARP_SIZE`).
  - If `nwarps`=0, go to DONE; otherwise go to ISSUE.
  - Software guarantees `num_threads`+`block_dim` < 2^32. Overflow is not detected.
- ISSUE:
  - Counters: `issued`, `retired`; `outstanding` = `issued`-`retired`.
  - `warp_valid`=1 while `issued` < `nwarps` and `outstanding` < `NUM_WARP_SLOTS`.
  - Payload for warp k=`issued`:
    - `warp_id`=k.
    - `warp_base_tid`=`base`+k*`WARP_SIZE`.
    - `warp_mask` has the low min(`WARP_SIZE`, `nthr`-k*`WARP_SIZE`) bits set.
    - `warp_block_id`=latched id.
  - A transfer occurs when `warp_valid`&&`warp_ready` at an edge; `issued` increments.
  - Once `warp_valid` is high, the payload is stable and `warp_valid` does not drop until the transfer.
  - `warp_retire` increments `retired`. Issue and retire in the same cycle leave `outstanding` unchanged and both counters update.
  - Go to DONE at the edge where `retired` reaches `nwarps`, using the next-count value.
- DONE (one cycle): `block_done`=1, then go to RELEASE.
- RELEASE: wait for `block_start`=0, then go to IDLE. A `block_start` held high after done never re-launches the same block.
- `warp_retire` with `outstanding`=0, or in any state other than ISSUE, is ignored and sets `protocol_err`.
- `block_start` changes outside IDLE are ignored.

## Timing
- Reset values:
  - State IDLE, all counters 0.
  - `block_done`, `warp_valid`, `busy` and `protocol_err` = 0.
  - `warp_*` payload outputs = 0.
- Reset is asynchronous. Asserting it mid-block drops `warp_valid` immediately and discards the block with no `block_done`.
- Cycle 0 is when `block_start` is sampled in IDLE:
  - Cycle 1: SETUP.
  - Cycle 2: first `warp_valid`, or `block_done` when `nwarps`=0.
- Back-to-back issue runs at 1 warp/cycle with `warp_ready` held high.
- `block_done` is high exactly one cycle, the cycle after the final `warp_retire` pulse.
- Earliest re-acceptance: one cycle after `block_start` is seen low in RELEASE.

## Test plan
- Full block, two warps:
  - Stimulus: `block_dim`=64, `num_threads`=256, `block_id`=2, `warp_ready`=1.
  - Response: warps 0 and 1 with `warp_base_tid` 128 and 160, mask 0xFFFFFFFF, on cycles 2 and 3.
  - Retire both; `block_done` high for one cycle, right after the second retire.
- Partial last block:
  - Stimulus: `num_threads`=200, `block_dim`=64, `block_id`=3.
  - Response: one warp, `warp_base_tid`=192, `warp_mask`=0x000000FF.
- Slot limit:
  - Stimulus: `block_dim`=256 (8 warps), `NUM_WARP_SLOTS`=4, no retires.
  - Response: exactly 4 transfers, then `warp_valid`=0.
  - Retire one: exactly one more warp (`warp_id`=4) is issued.
- Empty block:
  - Stimulus: `block_id`=5, `block_dim`=64, `num_threads`=256.
  - Response: `warp_valid` never rises; `block_done` on cycle 2.
- Release handshake:
  - Hold `block_start` high 10 cycles after done: no second block.
  - Drop it 1 cycle, then raise with `block_id`=7: new block accepted, warps carry `warp_block_id`=7.
- Reset and protocol error:
  - `rst`=0 mid-ISSUE: `warp_valid` drops immediately, `busy`=0.
  - After release, a `warp_retire` pulse in IDLE sets `protocol_err`=1, which stays set until reset.
